// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching upward from last_id+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_id,
    output logic                 valid,
    output logic [$clog2(N)-1:0] winner
);

    localparam int IDW = $clog2(N);

    assign valid = |req;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last_id) + i) % N;
            if (req[IDW'(idx)]) begin
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between N_REQ byte producers, round-robin with bursts of up to MAX_BURST bytes.
// Latency: req -> gnt/tx_byte one edge, -> tx_start one edge later when tx_busy is low.
// Backpressure: holds in LOAD while tx_busy is high; next byte waits for tx_done (optional watchdog: UART_ARB_TIMEOUT_EN).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_BURST    = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [BYTE_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [BYTE_W-1:0]        tx_byte,
    output logic                     tx_start,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     arb_busy,
    output logic                     tx_timeout
);

    localparam int             IDW       = $clog2(N_REQ);
    localparam logic [7:0]     BURST_MAX = 8'(MAX_BURST);
    // Reset "last owner" to the top index so requester 0 is searched first.
    localparam logic [IDW-1:0] LAST_RST  = IDW'(N_REQ - 1);

    arb_state_e        state;
    logic [7:0]        burst_cnt;
    logic [IDW-1:0]    last_id;
    logic              pick_vld;
    logic [IDW-1:0]    pick_id;
    logic              more;
    logic [BYTE_W-1:0] req_bytes [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[BYTE_W*gi +: BYTE_W];
    end

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req     (req),
        .last_id (last_id),
        .valid   (pick_vld),
        .winner  (pick_id)
    );

    // Owner keeps the serializer while it has bytes and its burst allowance is not used up.
    assign more     = req[owner_id] && (burst_cnt < BURST_MAX);
    assign arb_busy = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_pulse;

    assign tx_timeout = to_pulse;
`else
    // Watchdog compiled out; the expression folds to a constant 0.
    assign tx_timeout = (TIMEOUT_CLKS < 0);
`endif

    // Arbitration FSM: pick an owner, hand bytes one at a time, rotate at burst end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_id   <= LAST_RST;
            owner_id  <= '0;
            tx_byte   <= '0;
            gnt       <= '0;
            tx_start  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            to_pulse  <= 1'b0;
`endif
        end else begin
            gnt      <= '0;
            tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner_id     <= pick_id;
                        tx_byte      <= req_bytes[pick_id];
                        gnt[pick_id] <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        burst_cnt <= burst_cnt + 8'd1;
                        state     <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (more) begin
                            tx_byte       <= req_bytes[owner_id];
                            gnt[owner_id] <= 1'b1;
                            state         <= LOAD;
                        end else begin
                            last_id   <= owner_id;
                            burst_cnt <= '0;
                            state     <= IDLE;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        to_pulse  <= 1'b1;
                        last_id   <= owner_id;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: producer queues, a behavioural serializer and a grant-order model.
// Latency: n/a.
// Backpressure: serializer model drives tx_busy/tx_done; an optional forced-busy window stalls LOAD.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 16;
    localparam int CPB  = 4;
    localparam int TOC  = 12 * CPB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [7:0]     tx_byte;
    logic           tx_start;
    logic           tx_busy;
    logic           tx_done;
    logic [1:0]     owner_id;
    logic           arb_busy;
    logic           tx_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .MAX_BURST    (MAXB),
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TOC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .owner_id   (owner_id),
        .arb_busy   (arb_busy),
        .tx_timeout (tx_timeout)
    );

    int vec = 0;
    int err = 0;
    int cyc = 0;

    // Pending bytes per producer; front is the byte currently presented.
    logic [7:0] q [N][$];
    int         gseq [$];

    // Grant-order model
    int m_last, m_owner, m_cnt;
    bit m_active, m_force_end;

    // Serializer model and bookkeeping
    bit         ser_busy, dropping, drop_once, inflight, done_chk, done_ends, prev_start;
    bit         force_busy;
    int         ser_cnt, force_cnt, hold_arm, hold_used;
    int         cur_gnt_cyc, start_cyc, starts, to_seen;
    logic [7:0] cur_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i);
        req[i] = (q[i].size() > 0);
        req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) q[i].push_back(8'($urandom));
        set_req(i);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_last = N - 1; m_owner = 0; m_cnt = 0; m_active = 0; m_force_end = 0;
        inflight = 0; done_chk = 0; force_busy = 0; force_cnt = 0; hold_arm = 0; hold_used = 0;
    endtask

    // Who should own the next grant: the burst owner if its burst continues, else round-robin.
    task automatic predict(output int e);
        e = -1;
        if (m_active && !m_force_end) begin
            e = m_owner;
            m_cnt++;
        end else begin
            if (m_active) m_last = m_owner;
            m_force_end = 0;
            for (int k = 1; k <= N; k++) begin
                if (e < 0 && q[(m_last + k) % N].size() > 0) e = (m_last + k) % N;
            end
            if (e >= 0) begin
                m_owner = e; m_cnt = 1; m_active = 1;
            end
        end
    endtask

    task automatic handle_gnt();
        int g, e;
        g = -1;
        chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        for (int i = 0; i < N; i++) if (gnt[i]) g = i;
        predict(e);
        chk("gnt_id", 32'(g), 32'(e));
        chk("owner_id", 32'(owner_id), 32'(e));
        if (g >= 0 && q[g].size() > 0) begin
            chk("gnt_byte", 32'(tx_byte), 32'(q[g][0]));
            cur_byte = q[g].pop_front();
            set_req(g);
        end
        gseq.push_back(g);
        cur_gnt_cyc = cyc;
        hold_used = hold_arm;
        if (hold_arm > 0) begin
            force_busy = 1; force_cnt = hold_arm; hold_arm = 0;
        end
    endtask

    task automatic handle_start();
        chk("start_single", 32'(prev_start), 32'd0);
        chk("start_lat", 32'(cyc - cur_gnt_cyc), 32'(1 + hold_used));
        chk("start_byte", 32'(tx_byte), 32'(cur_byte));
        start_cyc = cyc; starts++; inflight = 1;
        ser_busy = 1; ser_cnt = $urandom_range(1, 6);
        if (drop_once) begin dropping = 1; drop_once = 0; end
    endtask

    task automatic handle_timeout();
`ifdef UART_ARB_TIMEOUT_EN
        chk("timeout_lat", 32'(cyc - start_cyc), 32'(TOC));
        m_force_end = 1; inflight = 0; to_seen++;
`else
        chk("timeout_tied", 32'(tx_timeout), 32'd0);
`endif
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive serializer/producers.
    task automatic step();
        @(negedge clk);
        cyc++;
        tx_done = 1'b0;
        if (done_chk) begin
            chk("busy_after_done", 32'(arb_busy), 32'(!done_ends));
            done_chk = 0;
        end
        if (force_cnt > 0) begin
            force_cnt--;
            if (force_cnt == 0) force_busy = 0;
        end
        if (ser_busy) begin
            ser_cnt--;
            if (ser_cnt == 0) begin
                ser_busy = 0;
                if (dropping) begin
                    dropping = 0;
                end else begin
                    tx_done = 1'b1;
                    if (inflight) begin
                        chk("byte_stable", 32'(tx_byte), 32'(cur_byte));
                        done_ends = !(q[m_owner].size() > 0 && m_cnt < MAXB);
                        if (done_ends) m_force_end = 1;
                        done_chk = 1;
                        inflight = 0;
                    end
                end
            end
        end
        if (gnt !== '0) handle_gnt();
        if (tx_start === 1'b1) handle_start();
        if (tx_timeout === 1'b1) handle_timeout();
        prev_start = (tx_start === 1'b1);
        tx_busy = ser_busy | force_busy;
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while (n < bound && !(all_empty() && arb_busy === 1'b0 && !ser_busy && !done_chk)) begin
            step();
            n++;
        end
        if (n >= bound) begin
            vec++; err++;
            $error("FAIL %s drain: not idle after %0d cycles, required idle", tag, bound);
        end
    endtask

    task automatic wait_starts(input string tag, input int target, input int bound);
        int n;
        n = 0;
        while (starts < target && n < bound) begin step(); n++; end
        if (starts < target) begin
            vec++; err++;
            $error("FAIL %s wait: %0d starts, required %0d", tag, starts, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, lowest;
        rst_n = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        ser_busy = 0; dropping = 0; drop_once = 0; prev_start = 0; done_ends = 0;
        ser_cnt = 0; cur_gnt_cyc = 0; start_cyc = 0; starts = 0; to_seen = 0; cur_byte = '0;
        model_reset();

        // Reset values
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_owner", 32'(owner_id), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_timeout", 32'(tx_timeout), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // tx_done while idle is ignored
        tx_done = 1'b1;
        step();
        chk("idle_done_busy", 32'(arb_busy), 32'd0);
        chk("idle_done_gnt", 32'(gnt), 32'd0);

        // Test 1: req=0101, requester 0 first, start one cycle after gnt
        q[0].push_back(8'hA5); set_req(0);
        q[2].push_back(8'h3C); set_req(2);
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_byte", 32'(tx_byte), 32'hA5);
        chk("t1_owner", 32'(owner_id), 32'd0);
        step();
        chk("t1_start", 32'(tx_start), 32'd1);
        drain("t1", 200);

        // Test 3: single byte from requester 1; a req3 glitch that never gets a grant
        load(1, 1);
        wait_starts("t3", starts + 1, 50);
        req[3] = 1'b1;
        step();
        req[3] = 1'b0;
        drain("t3", 200);

        // Test 4: serializer busy held 50 cycles while in LOAD
        hold_arm = 50;
        load(2, 1);
        drain("t4", 300);

        // Test 2: burst limit with a competing requester
        gseq.delete();
        load(0, 20);
        load(2, 1);
        drain("t2", 2000);
        run = 0;
        while (run < gseq.size() && gseq[run] == 0) run++;
        chk("t2_total", 32'(gseq.size()), 32'd21);
        chk("t2_run", 32'(run), 32'd16);
        chk("t2_next", 32'((gseq.size() > 16) ? gseq[16] : -1), 32'd2);
        chk("t2_back", 32'((gseq.size() > 17) ? gseq[17] : -1), 32'd0);

        // Randomized traffic mixes
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 5));
            drain("rand", 2000);
        end

        // Test 5: reset while waiting for tx_done
        load(1, 5); load(2, 2); load(3, 3);
        wait_starts("t5", starts + 2, 200);
        rst_n = 1'b0;
        model_reset();
        step();
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_tx_start", 32'(tx_start), 32'd0);
        chk("t5_tx_byte", 32'(tx_byte), 32'd0);
        chk("t5_owner", 32'(owner_id), 32'd0);
        chk("t5_arb_busy", 32'(arb_busy), 32'd0);
        chk("t5_timeout", 32'(tx_timeout), 32'd0);
        for (int k = 0; k < 7; k++) step();
        rst_n = 1'b1;
        lowest = -1;
        for (int i = 0; i < N; i++) if (lowest < 0 && q[i].size() > 0) lowest = i;
        gseq.delete();
        drain("t5", 2000);
        chk("t5_first", 32'((gseq.size() > 0) ? gseq[0] : -1), 32'(lowest));

`ifdef UART_ARB_TIMEOUT_EN
        // Test 6: tx_done never arrives for one byte
        gseq.delete();
        load(1, 2); load(3, 1);
        drop_once = 1;
        drain("t6", 1000);
        chk("t6_timeouts", 32'(to_seen), 32'd1);
        chk("t6_grants", 32'(gseq.size()), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
